// File: rtl/axis_slave_rx.sv
// AXI4-Stream receive end: elastic first-word-fall-through FIFO with beat/packet tracking.
// Define AXIS_SLAVE_STRB_MASK_EN to zero the bytes whose TSTRB bit is low as they are written.
module axis_slave_rx #(
  parameter int FIFO_DEPTH           = 4,
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int PKT_CNT_WIDTH        = 16
) (
  input  logic                                S_AXIS_ACLK,
  input  logic                                S_AXIS_ARESET,
  input  logic                                axis_en,
  input  logic                                axis_clear,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
  input  logic                                S_AXIS_TLAST,
  input  logic                                S_AXIS_TVALID,
  output logic                                S_AXIS_TREADY,
  input  logic                                rd_en,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]     rd_data,
  output logic                                rd_last,
  output logic                                rd_valid,
  output logic                                fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_count,
  output logic                                pkt_done,
  output logic [PKT_CNT_WIDTH-1:0]            pkt_cnt
);

  localparam int W      = C_S_AXIS_TDATA_WIDTH;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int BEAT_W = 16;

  logic [W:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [W-1:0]        wr_data;
  logic                push;
  logic                pop;

`ifdef AXIS_SLAVE_STRB_MASK_EN
  always_comb begin
    wr_data = '0;
    for (int i = 0; i < W/8; i++) begin
      wr_data[i*8 +: 8] = S_AXIS_TSTRB[i] ? S_AXIS_TDATA[i*8 +: 8] : 8'h00;
    end
  end
`else
  logic unused_strb;
  assign unused_strb = ^S_AXIS_TSTRB;
  assign wr_data     = S_AXIS_TDATA;
`endif

  // Ready is taken off during reset and clear so no beat slips in while state is being zeroed.
  assign S_AXIS_TREADY = axis_en & ~axis_clear & ~S_AXIS_ARESET &
                         (fifo_count != CW'(FIFO_DEPTH));
  assign rd_valid      = (fifo_count != '0);
  assign fifo_empty    = ~rd_valid;
  assign push          = S_AXIS_TVALID & S_AXIS_TREADY;
  assign pop           = rd_en & rd_valid;
  assign rd_data       = mem[rd_ptr][W-1:0];
  assign rd_last       = rd_valid & mem[rd_ptr][W];

  always_ff @(posedge S_AXIS_ACLK) begin
    if (push) begin
      mem[wr_ptr] <= {S_AXIS_TLAST, wr_data};
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET || axis_clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      beat_cnt   <= '0;
      pkt_cnt    <= '0;
      pkt_done   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      pkt_done <= push & S_AXIS_TLAST;
      if (push) begin
        if (S_AXIS_TLAST) begin
          beat_cnt <= '0;
          pkt_cnt  <= pkt_cnt + PKT_CNT_WIDTH'(1);
        end else begin
          beat_cnt <= beat_cnt + BEAT_W'(1);
        end
      end
    end
  end

endmodule
